// File: rtl/config_chain_loader_if.sv
// Host word interface for config_chain_loader.
// Ports (signals):
//   word_in    - configuration word, bit 0 is shifted into the chain first
//   word_valid - word_in holds a valid word
//   word_ready - loader accepts word_in on an edge where valid & ready
// Handshake: a word transfers on every clk edge where word_valid and
// word_ready are both 1. word_ready never depends on word_valid, and the
// host may raise word_valid at any time and holds word_in stable while it
// is high.
interface config_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serial configuration chain loader.
// Serializes host words LSB first into a PE-array configuration chain and
// gates chain shifting through cfg_shift (ICG enable). An optional verify
// pass rotates the chain once through itself and compares a CRC-8 of the
// read-back bits against the CRC-8 of the loaded bits.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   start        - begin a load (sampled in IDLE only)
//   verify_en    - sampled with start, run a verify pass after the load
//   host_if      - word_in / word_valid / word_ready handshake (slave side)
//   cfg_bit      - bit driven into the chain config_in
//   cfg_shift    - chain shift enable, chain shifts at the end of the cycle
//   chain_out    - chain config_out (last cell)
//   busy         - high in LOAD and VERIFY
//   done         - one-cycle pulse at completion
//   error        - verify CRC mismatch, sticky until the next accepted start
//   dbg_state_o  - current FSM state (0 IDLE, 1 LOAD, 2 VERIFY)
module config_chain_loader #(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    verify_en,
  config_chain_loader_if.slave    host_if,
  output logic                    cfg_bit,
  output logic                    cfg_shift,
  input  logic                    chain_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e            state_q;
  logic [WORD_W-1:0] buf_q;
  logic [CNT_W-1:0]  cnt_q;        // bits left in buf_q
  logic [CNT_W-1:0]  bits_left_q;  // load shifts still to issue
  logic [CNT_W-1:0]  unbuf_q;      // chain bits not yet taken from the host
  logic [CNT_W-1:0]  ver_left_q;
  logic [7:0]        load_crc_q;
  logic [7:0]        rb_crc_q;
  logic              verify_q;
  logic              done_q;
  logic              error_q;

  logic              shift_load_d;
  logic              accept_d;
  logic [CNT_W-1:0]  take_d;
  logic [7:0]        load_crc_d;
  logic [7:0]        rb_crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    shift_load_d = (state_q == S_LOAD) && (cnt_q != '0);
    cfg_shift    = shift_load_d || (state_q == S_VERIFY);
    // Verify rotates the chain: its own output is fed straight back in.
    cfg_bit      = (state_q == S_VERIFY) ? chain_out :
                   (state_q == S_LOAD)   ? buf_q[0]  : 1'b0;
    // A new word may land in the same cycle the last buffered bit leaves,
    // which keeps shifting continuous across word boundaries.
    host_if.word_ready = (state_q == S_LOAD) && (unbuf_q != '0) &&
                         ((cnt_q == '0) || ((cnt_q == ONE_C) && shift_load_d));
    accept_d     = host_if.word_ready && host_if.word_valid;
    // The final word only contributes the bits the chain still needs.
    take_d       = (unbuf_q < WORD_C) ? unbuf_q : WORD_C;
    load_crc_d   = crc8_step(load_crc_q, buf_q[0]);
    rb_crc_d     = crc8_step(rb_crc_q, chain_out);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      bits_left_q <= '0;
      unbuf_q     <= '0;
      ver_left_q  <= '0;
      load_crc_q  <= 8'h00;
      rb_crc_q    <= 8'h00;
      verify_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            bits_left_q <= LEN_C;
            unbuf_q     <= LEN_C;
            cnt_q       <= '0;
            load_crc_q  <= 8'h00;
            error_q     <= 1'b0;
            verify_q    <= verify_en;
          end
        end
        S_LOAD: begin
          if (shift_load_d) begin
            buf_q       <= buf_q >> 1;
            cnt_q       <= cnt_q - ONE_C;
            bits_left_q <= bits_left_q - ONE_C;
            load_crc_q  <= load_crc_d;
            if (bits_left_q == ONE_C) begin
              if (verify_q) begin
                state_q    <= S_VERIFY;
                ver_left_q <= LEN_C;
                rb_crc_q   <= 8'h00;
              end else begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          // Acceptance only happens when the buffer empties this cycle,
          // so it safely overrides the shift update above.
          if (accept_d) begin
            buf_q   <= host_if.word_in;
            cnt_q   <= take_d;
            unbuf_q <= unbuf_q - take_d;
          end
        end
        S_VERIFY: begin
          rb_crc_q   <= rb_crc_d;
          ver_left_q <= ver_left_q - ONE_C;
          if (ver_left_q == ONE_C) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            error_q <= (rb_crc_d != load_crc_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;
  localparam int CL = 14;
  localparam int WW = 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic verify_en = 1'b0;
  logic cfg_bit, cfg_shift, chain_out, busy, done, error;
  logic [1:0] dbg_state;

  config_chain_loader_if #(.WORD_W(WW)) hif ();

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
    .host_if(hif), .cfg_bit(cfg_bit), .cfg_shift(cfg_shift),
    .chain_out(chain_out), .busy(busy), .done(done), .error(error),
    .dbg_state_o(dbg_state)
  );

  // Behavioural model of the 14-cell configuration chain.
  logic [CL-1:0] chain_m = '0;
  assign chain_out = chain_m[CL-1];
  always @(posedge clk) if (cfg_shift) chain_m <= {chain_m[CL-2:0], cfg_bit};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0]  exp_q[$];       // expected cfg_bit per load shift
  logic [24:0] done_exp_q[$];  // {error, ready cycles, bubbles, load shifts, verify shifts}
  int m_rdy = 0, m_bub = 0, m_l = 0, m_v = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [0:0]  eb;
    logic [24:0] ed;
    if (reset) begin
      if (dbg_state == ST_LOAD) begin
        if (hif.word_ready) m_rdy++;
        if (cfg_shift) begin
          m_l++;
          if (exp_q.size() == 0) chk("load_bit_unexpected", 32'd1, 32'd0);
          else begin
            eb = exp_q.pop_front();
            chk("load_bit", 32'(cfg_bit), 32'(eb));
          end
        end else m_bub++;
      end else begin
        chk("ready_outside_load", 32'(hif.word_ready), 32'd0);
      end
      if (dbg_state == ST_VERIFY) begin
        if (cfg_shift) m_v++;
        chk("verify_rotate_bit", 32'(cfg_bit), 32'(chain_out));
      end
      if (!busy) chk("idle_no_shift", 32'(cfg_shift), 32'd0);
      if (done) begin
        if (done_exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          ed = done_exp_q.pop_front();
          chk("done_error", 32'(error), 32'(ed[24]));
          chk("ready_cycles", 32'(m_rdy), 32'(ed[23:20]));
          chk("bubble_cycles", 32'(m_bub), 32'(ed[19:16]));
          chk("load_shifts", 32'(m_l), 32'(ed[15:8]));
          chk("verify_shifts", 32'(m_v), 32'(ed[7:0]));
        end
        m_rdy = 0; m_bub = 0; m_l = 0; m_v = 0;
      end else if (!busy) begin
        m_rdy = 0; m_bub = 0; m_l = 0; m_v = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic v);
    @(negedge clk);
    start = 1'b1;
    verify_en = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    verify_en = 1'b0;
  endtask

  // Waits for word_ready, holds valid low for gap more cycles, then transfers.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    hif.word_valid = 1'b0;
    @(negedge clk);
    while (!hif.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("word_ready_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (gap) @(negedge clk);
    hif.word_in = w;
    hif.word_valid = 1'b1;
    @(posedge clk);
    #1;
    hif.word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state != s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("state_timeout", 32'd0, 32'd1);
  endtask

  // Expected bits for words 0xA5, 0x3C: 1,0,1,0,0,1,0,1,0,0,1,1,1,1
  task automatic push_bits();
    logic [13:0] seq;
    seq = 14'b11110010100101;  // bit i = i-th shifted bit
    for (int i = 0; i < CL; i++) exp_q.push_back(seq[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    hif.word_in = '0;
    hif.word_valid = 1'b0;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_shift", 32'(cfg_shift), 32'd0);
    chk("rst_ready", 32'(hif.word_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: plain load, continuous words
    push_bits();
    done_exp_q.push_back({1'b0, 4'd2, 4'd1, 8'd14, 8'd0});
    do_start(1'b0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_done();
    chk("chain_after_load", 32'(chain_m), 32'h294F);

    // 2: load with a 3-cycle gap before the second word
    push_bits();
    done_exp_q.push_back({1'b0, 4'd5, 4'd4, 8'd14, 8'd0});
    do_start(1'b0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 3);
    wait_done();
    chk("chain_after_stall_load", 32'(chain_m), 32'h294F);

    // 3: load + verify, chain untouched
    push_bits();
    done_exp_q.push_back({1'b0, 4'd2, 4'd1, 8'd14, 8'd14});
    do_start(1'b1);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_done();
    chk("chain_after_verify", 32'(chain_m), 32'h294F);

    // 4: load + verify with chain bit 5 corrupted before the rotate
    push_bits();
    done_exp_q.push_back({1'b1, 4'd2, 4'd1, 8'd14, 8'd14});
    do_start(1'b1);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_state(ST_VERIFY);
    chain_m[5] = ~chain_m[5];
    wait_done();
    chk("chain_after_bad_verify", 32'(chain_m), 32'h296F);
    repeat (3) @(negedge clk);
    chk("error_sticky", 32'(error), 32'd1);

    // 5: reset after 5 load shifts, then a full reload
    push_bits();
    do_start(1'b0);
    @(negedge clk);
    chk("error_cleared_by_start", 32'(error), 32'd0);
    send_word(8'hA5, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_shift", 32'(cfg_shift), 32'd0);
    chk("midrst_ready", 32'(hif.word_ready), 32'd0);
    exp_q.delete();
    push_bits();
    done_exp_q.push_back({1'b0, 4'd2, 4'd1, 8'd14, 8'd0});
    do_start(1'b0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_done();

    // 6: start pulsed during LOAD is ignored
    push_bits();
    done_exp_q.push_back({1'b0, 4'd2, 4'd1, 8'd14, 8'd0});
    do_start(1'b0);
    send_word(8'hA5, 0);
    do_start(1'b1);
    send_word(8'h3C, 0);
    wait_done();

    // 7: start together with reset stays IDLE
    @(negedge clk);
    start = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("start_with_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("start_with_reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_still_idle", 32'(dbg_state), 32'(ST_IDLE));

    repeat (4) @(negedge clk);
    chk("bits_left_in_queue", 32'(exp_q.size()), 32'd0);
    chk("dones_outstanding", 32'(done_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Drives the serial configuration chain of a PE array from the transmitting end. It shifts a bitstream into the chain's config_in and gates chain shifting through an enable that feeds an external clock-gate cell.
- Takes configuration words from the host over a valid/ready interface and serializes them LSB first.
- Optional verify pass: rotates the chain once through itself, leaving contents unchanged, and compares a CRC-8 of the bits read back against the CRC-8 of the bits loaded.

Parameters:
- CHAIN_LEN, 14, total configuration bits in the chain (≥1).
- WORD_W, 32, host word width (≥1).
- CNT_W, 16, width of bit counters; requires 2^CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  single clock; the chain's gated clock is derived from it.
- reset  input  1  synchronous, active-low; the block resets on a clk edge where reset==0.
- start  input  1  begin load; sampled only in IDLE.
- verify_en  input  1  sampled with start; 1 = run the verify pass after load.
- word_in  input  WORD_W  configuration word; bit 0 is shifted first.
- word_valid  input  1  word_in valid.
- word_ready  output  1  word accepted on a clk edge where word_valid & word_ready.
- cfg_bit  output  1  to chain config_in.
- cfg_shift  output  1  chain shift enable (ICG enable); the chain shifts on the clk edge ending a cycle with cfg_shift=1.
- chain_out  input  1  chain config_out (last cell), combinational from chain state.
- busy  output  1  high in LOAD/VERIFY.
- done  output  1  one-cycle pulse at completion.
- error  output  1  verify CRC mismatch; sticky until next accepted start.

Behaviour:
- Reset (reset==0 at edge): state=IDLE; buffer count=0; CRCs=0; done=0; error=0. busy, cfg_shift and word_ready are 0 the cycle after. Reset wins over all inputs. A reset mid-operation leaves chain contents undefined; software must reload.
- States: IDLE, LOAD, VERIFY.
- IDLE:
  - Outputs cfg_shift=0, word_ready=0.
  - start=1 at edge T: state=LOAD, bits_left=CHAIN_LEN, load_crc=0, error=0, verify flag=verify_en. busy=1 from cycle T+1.
- LOAD:
  - Holds a WORD_W shift buffer and a bit count cnt.
  - cfg_shift = (cnt>0); cfg_bit = buf[0]. Both derive from registers only.
  - On a shift edge: buf>>=1, cnt-=1, bits_left-=1, load_crc updated with cfg_bit.
  - word_ready = (state==LOAD) & (words still needed) & (cnt==0 | (cnt==1 & cfg_shift)). This allows one shift per cycle with back-to-back words.
  - Accepted word: buf=word_in, cnt=min(WORD_W, remaining bits not yet buffered). The excess upper bits of the final word are discarded.
  - No word available: cfg_shift=0 (stall bubble); no shift, no counter change.
  - Last shift edge (bits_left 1→0): go to VERIFY if verify flag=1 (ver_left=CHAIN_LEN, rb_crc=0); otherwise go to IDLE with done=1 the following cycle.
- VERIFY:
  - cfg_shift=1 every cycle; cfg_bit = chain_out (combinational passthrough, rotate).
  - Each edge: rb_crc updated with chain_out; ver_left-=1.
  - After CHAIN_LEN shifts the chain equals its post-load contents and the bits read back equal the loaded sequence in order.
  - Last edge: state=IDLE; done=1 next cycle; error=(rb_crc_next != load_crc) in the same cycle as done.
- CRC-8: poly 0x07, init 0x00, bit-serial. fb = crc[7]^bit; crc_next = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
- Latency:
  - Without stalls, LOAD issues exactly CHAIN_LEN consecutive shift cycles, the first in cycle T+2 (word accepted in T+1).
  - VERIFY adds CHAIN_LEN cycles.
  - done follows the final shift by one cycle.
- Control rules:
  - start is ignored while busy; verify_en is ignored outside the start cycle.
  - The word interface is never ready outside LOAD.
  - No shift ever occurs in IDLE.
- Total shift cycles per operation: exactly CHAIN_LEN (load) plus CHAIN_LEN (verify), never more, regardless of stalls.

Test Plan:
- CHAIN_LEN=14, WORD_W=8; start with verify_en=0; words 0xA5, 0x3C presented continuously -> 14 consecutive shift cycles; cfg_bit = 1,0,1,0,0,1,0,1,0,0,1,1,1,1; word_ready is never high for a third word; done pulses once; error=0.
- Same load with word_valid low for 3 cycles between words -> cfg_shift low for exactly those 3 cycles; still 14 shifts and an identical bit sequence.
- Load as above with verify_en=1 against a 14-bit shift-register model -> 14 VERIFY shifts; model contents after equal contents before VERIFY; done pulses; error=0.
- Same as the verify case, but flip model bit 5 before VERIFY -> error=1 coincident with done; error stays 1 until the next start.
- reset=0 after 5 LOAD shifts -> next cycle busy=0, cfg_shift=0, word_ready=0; a following start produces a full 14-shift load.
- start pulsed mid-LOAD is ignored (shift count unchanged); start=1 with reset=0 on the same edge -> stays IDLE.
